// File: rtl/psram_arb_pkg.sv
// Shared encodings for the PSRAM arbiter: FSM states, owner codes and the
// read data returned when a transaction times out (PSRAM_ARB_TIMEOUT_EN builds).
package psram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_VID  = 2'b10
  } owner_e;

  localparam logic [15:0] TIMEOUT_RDATA = 16'hDEAD;

endpackage

// File: rtl/psram_arbiter_if.sv
// Bundles the CPU, video and controller-side signals of the PSRAM arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface psram_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);

  logic              i_cpu_req;
  logic              i_cpu_we;
  logic [ADDR_W-1:0] i_cpu_addr;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              o_cpu_done;
  logic [DATA_W-1:0] o_cpu_rdata;

  logic              i_vid_req;
  logic [ADDR_W-1:0] i_vid_addr;
  logic              o_vid_done;
  logic [DATA_W-1:0] o_vid_rdata;

  logic              o_mem_stb;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_din;
  logic              i_mem_busy;
  logic              i_mem_done;
  logic [DATA_W-1:0] i_mem_dout;

  logic [1:0]        o_owner;
  logic              o_timeout;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  i_vid_req, i_vid_addr,
    input  i_mem_busy, i_mem_done, i_mem_dout,
    output o_cpu_done, o_cpu_rdata, o_vid_done, o_vid_rdata,
    output o_mem_stb, o_mem_we, o_mem_addr, o_mem_din,
    output o_owner, o_timeout
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output i_vid_req, i_vid_addr,
    output i_mem_busy, i_mem_done, i_mem_dout,
    input  o_cpu_done, o_cpu_rdata, o_vid_done, o_vid_rdata,
    input  o_mem_stb, o_mem_we, o_mem_addr, o_mem_din,
    input  o_owner, o_timeout
  );

endinterface

// File: rtl/psram_arb_pick.sv
// Grant decision for the PSRAM arbiter: video has fixed priority unless the
// CPU has already waited CPU_MAX_WAIT consecutive video grants.
module psram_arb_pick #(
  parameter int CPU_MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_eval,
  input  logic i_cpu_req,
  input  logic i_vid_req,
  output logic o_grant_cpu,
  output logic o_grant_vid
);

  localparam int CNT_W = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CPU_MAX_WAIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starved;

  // The counter only moves on a grant, so it tracks consecutive video wins
  // while the CPU is waiting.
  always_comb begin
    starved      = i_cpu_req && (starve_cnt_q == CNT_MAX);
    o_grant_vid  = i_eval && i_vid_req && !starved;
    o_grant_cpu  = i_eval && i_cpu_req && !o_grant_vid;
    starve_cnt_d = starve_cnt_q;
    if (o_grant_vid && i_cpu_req) begin
      if (starve_cnt_q != CNT_MAX) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end else if (o_grant_vid || o_grant_cpu) begin
      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Shares one PSRAM controller between the CPU bus and the video fetch engine.
// Define PSRAM_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYC cycles.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int CPU_MAX_WAIT = 4
`ifdef PSRAM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input logic            i_clk,
  input logic            i_rst,
  psram_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              mem_stb_q, mem_stb_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              cpu_done_q, cpu_done_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              vid_done_q, vid_done_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic              grant_cpu, grant_vid;
  logic              finish;
  logic [DATA_W-1:0] finish_data;

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  psram_arb_pick #(
    .CPU_MAX_WAIT(CPU_MAX_WAIT)
  ) u_pick (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_eval     ((state_q == ST_IDLE) && !bus.i_mem_busy),
    .i_cpu_req  (bus.i_cpu_req),
    .i_vid_req  (bus.i_vid_req),
    .o_grant_cpu(grant_cpu),
    .o_grant_vid(grant_vid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_stb_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    cpu_done_d  = 1'b0;
    vid_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    finish      = 1'b0;
    finish_data = bus.i_mem_dout;
`ifdef PSRAM_ARB_TIMEOUT_EN
    tmo_cnt_d   = '0;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (grant_vid) begin
          owner_d    = OWN_VID;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.i_vid_addr;
          mem_din_d  = '0;
          state_d    = ST_ISSUE;
        end else if (grant_cpu) begin
          owner_d    = OWN_CPU;
          mem_we_d   = bus.i_cpu_we;
          mem_addr_d = bus.i_cpu_addr;
          mem_din_d  = bus.i_cpu_wdata;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_stb_d = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_mem_done) begin
          finish = 1'b1;
`ifdef PSRAM_ARB_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          finish      = 1'b1;
          finish_data = DATA_W'(TIMEOUT_RDATA);
          timeout_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        end
        if (finish) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Completion data goes to whoever owns the bus, writes included.
    if (finish) begin
      if (owner_q == OWN_CPU) begin
        cpu_done_d  = 1'b1;
        cpu_rdata_d = finish_data;
      end else begin
        vid_done_d  = 1'b1;
        vid_rdata_d = finish_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      vid_done_q  <= 1'b0;
      vid_rdata_q <= '0;
`ifdef PSRAM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_stb_q   <= mem_stb_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      cpu_done_q  <= cpu_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_done_q  <= vid_done_d;
      vid_rdata_q <= vid_rdata_d;
`ifdef PSRAM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign bus.o_mem_stb   = mem_stb_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_din   = mem_din_q;
  assign bus.o_cpu_done  = cpu_done_q;
  assign bus.o_cpu_rdata = cpu_rdata_q;
  assign bus.o_vid_done  = vid_done_q;
  assign bus.o_vid_rdata = vid_rdata_q;
  assign bus.o_owner     = owner_q;
`ifdef PSRAM_ARB_TIMEOUT_EN
  assign bus.o_timeout   = timeout_q;
`else
  assign bus.o_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed self-checking bench for psram_arbiter with a simple controller model.
// With PSRAM_ARB_TIMEOUT_EN defined it also exercises the timeout path (TIMEOUT_CYC = 20).
module tb_psram_arbiter;

  logic clk = 1'b0;
  logic rst;

  int compared   = 0;
  int mismatched = 0;

  int          ctrl_delay = 6;
  logic        ctrl_en    = 1'b1;
  logic [15:0] ctrl_data  = 16'h0000;
  int          kill_req   = 0;
  int          kill_ack   = 0;

  int lat, other_seen, stb_seen, cnt;
  logic [1:0] exp_owner [10];

  psram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) bus ();

  psram_arbiter #(
    .ADDR_W      (24),
    .DATA_W      (16),
    .CPU_MAX_WAIT(4)
`ifdef PSRAM_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(20)
`endif
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Controller model: answers each strobe with a done pulse ctrl_delay cycles later.
  initial begin
    bus.i_mem_done = 1'b0;
    bus.i_mem_dout = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.o_mem_stb && ctrl_en) begin
        repeat (ctrl_delay) @(negedge clk);
        if (kill_req != kill_ack) begin
          kill_ack = kill_req;
        end else begin
          bus.i_mem_done = 1'b1;
          bus.i_mem_dout = ctrl_data;
          @(negedge clk);
          bus.i_mem_done = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cpu_req, input logic cpu_we, input logic [23:0] cpu_addr,
                               input logic [15:0] cpu_wdata, input logic vid_req, input logic [23:0] vid_addr);
    bus.i_cpu_req   = cpu_req;
    bus.i_cpu_we    = cpu_we;
    bus.i_cpu_addr  = cpu_addr;
    bus.i_cpu_wdata = cpu_wdata;
    bus.i_vid_req   = vid_req;
    bus.i_vid_addr  = vid_addr;
  endtask

  task automatic waitStb(input int limit, output int cycles);
    cycles = -1;
    for (int k = 1; k <= limit && cycles < 0; k++) begin
      @(negedge clk);
      if (bus.o_mem_stb) cycles = k;
    end
  endtask

  task automatic waitDone(input bit is_cpu, input int limit, output int cycles,
                          output int other, output int stbs);
    cycles = -1;
    other  = 0;
    stbs   = 0;
    for (int k = 1; k <= limit && cycles < 0; k++) begin
      @(negedge clk);
      if (bus.o_mem_stb) stbs++;
      if (is_cpu ? bus.o_vid_done : bus.o_cpu_done) other++;
      if (is_cpu ? bus.o_cpu_done : bus.o_vid_done) cycles = k;
    end
  endtask

  initial begin
    exp_owner = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    rst = 1'b1;
    bus.i_mem_busy = 1'b0;
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_stb", bus.o_mem_stb, 0);
    checkOutput("rst_owner", bus.o_owner, 0);
    checkOutput("rst_cpu_done", bus.o_cpu_done, 0);
    checkOutput("rst_vid_done", bus.o_vid_done, 0);
    checkOutput("rst_timeout", bus.o_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] CPU write alone");
    ctrl_delay = 6;
    ctrl_data  = 16'h5A5A;
    applyStimulus(1'b1, 1'b1, 24'h000123, 16'hBEEF, 1'b0, 24'h0);
    waitStb(10, lat);
    checkOutput("wr_stb_lat", lat, 2);
    checkOutput("wr_we", bus.o_mem_we, 1);
    checkOutput("wr_addr", bus.o_mem_addr, 32'h000123);
    checkOutput("wr_din", bus.o_mem_din, 32'hBEEF);
    checkOutput("wr_owner", bus.o_owner, 2'b01);
    waitDone(1'b1, 30, lat, other_seen, stb_seen);
    checkOutput("wr_done_lat", lat, 7);
    checkOutput("wr_vid_done_quiet", other_seen, 0);
    checkOutput("wr_stb_single", stb_seen, 0);
    checkOutput("wr_rdata", bus.o_cpu_rdata, 32'h5A5A);
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    @(negedge clk);
    checkOutput("wr_done_pulse", bus.o_cpu_done, 0);
    checkOutput("wr_owner_idle", bus.o_owner, 0);

    $display("[TB] video read alone");
    ctrl_data = 16'h1234;
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b1, 24'h001000);
    waitStb(10, lat);
    checkOutput("vid_stb_lat", lat, 2);
    checkOutput("vid_we", bus.o_mem_we, 0);
    checkOutput("vid_addr", bus.o_mem_addr, 32'h001000);
    checkOutput("vid_owner", bus.o_owner, 2'b10);
    waitDone(1'b0, 30, lat, other_seen, stb_seen);
    checkOutput("vid_done_lat", lat, 7);
    checkOutput("vid_rdata", bus.o_vid_rdata, 32'h1234);
    checkOutput("vid_cpu_done_quiet", other_seen, 0);
    checkOutput("vid_cpu_rdata_held", bus.o_cpu_rdata, 32'h5A5A);
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    @(negedge clk);
    checkOutput("vid_owner_idle", bus.o_owner, 0);

    $display("[TB] controller busy holds off strobe");
    ctrl_data = 16'h7777;
    bus.i_mem_busy = 1'b1;
    applyStimulus(1'b1, 1'b0, 24'h000042, 16'h0, 1'b0, 24'h0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_mem_stb) cnt++;
    end
    checkOutput("busy_no_stb", cnt, 0);
    checkOutput("busy_owner", bus.o_owner, 0);
    bus.i_mem_busy = 1'b0;
    waitStb(10, lat);
    checkOutput("busy_stb_lat", lat, 2);
    waitDone(1'b1, 30, lat, other_seen, stb_seen);
    checkOutput("busy_stb_single", stb_seen, 0);
    checkOutput("busy_done_lat", lat, 7);
    checkOutput("busy_rdata", bus.o_cpu_rdata, 32'h7777);
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    @(negedge clk);

    $display("[TB] both requesting, starvation guard");
    ctrl_delay = 3;
    applyStimulus(1'b1, 1'b0, 24'h000200, 16'h0, 1'b1, 24'h000300);
    for (int i = 0; i < 10; i++) begin
      waitStb(40, lat);
      checkOutput($sformatf("grant_%0d", i), {30'd0, bus.o_owner}, {30'd0, exp_owner[i]});
    end
    waitDone(1'b1, 30, lat, other_seen, stb_seen);
    checkOutput("fair_last_cpu_done", lat, 4);
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    @(negedge clk);

    $display("[TB] reset during WAIT");
    ctrl_delay = 6;
    ctrl_data  = 16'h9999;
    applyStimulus(1'b1, 1'b1, 24'h000055, 16'h1111, 1'b0, 24'h0);
    waitStb(10, lat);
    checkOutput("rstw_stb_lat", lat, 2);
    @(negedge clk);
    rst = 1'b1;
    kill_req++;
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    @(negedge clk);
    checkOutput("rstw_stb", bus.o_mem_stb, 0);
    checkOutput("rstw_we", bus.o_mem_we, 0);
    checkOutput("rstw_addr", bus.o_mem_addr, 0);
    checkOutput("rstw_din", bus.o_mem_din, 0);
    checkOutput("rstw_owner", bus.o_owner, 0);
    checkOutput("rstw_cpu_rdata", bus.o_cpu_rdata, 0);
    checkOutput("rstw_vid_rdata", bus.o_vid_rdata, 0);
    rst = 1'b0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.o_cpu_done) cnt++;
    end
    checkOutput("rstw_no_done", cnt, 0);
    ctrl_data = 16'h4321;
    applyStimulus(1'b1, 1'b0, 24'h000066, 16'h0, 1'b0, 24'h0);
    waitStb(10, lat);
    checkOutput("rstw_new_stb_lat", lat, 2);
    checkOutput("rstw_new_addr", bus.o_mem_addr, 32'h000066);
    waitDone(1'b1, 30, lat, other_seen, stb_seen);
    checkOutput("rstw_new_done_lat", lat, 7);
    checkOutput("rstw_new_rdata", bus.o_cpu_rdata, 32'h4321);
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    @(negedge clk);

`ifdef PSRAM_ARB_TIMEOUT_EN
    $display("[TB] timeout path");
    ctrl_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 24'h000077, 16'h0, 1'b0, 24'h0);
    waitStb(10, lat);
    checkOutput("tmo_stb_lat", lat, 2);
    waitDone(1'b1, 60, lat, other_seen, stb_seen);
    checkOutput("tmo_done_lat", lat, 20);
    checkOutput("tmo_rdata", bus.o_cpu_rdata, 32'hDEAD);
    checkOutput("tmo_flag", bus.o_timeout, 1);
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    @(negedge clk);
    ctrl_en   = 1'b1;
    ctrl_data = 16'h0BAD;
    applyStimulus(1'b1, 1'b0, 24'h000078, 16'h0, 1'b0, 24'h0);
    waitStb(10, lat);
    waitDone(1'b1, 30, lat, other_seen, stb_seen);
    checkOutput("tmo_after_done_lat", lat, 7);
    checkOutput("tmo_after_rdata", bus.o_cpu_rdata, 32'h0BAD);
    checkOutput("tmo_sticky", bus.o_timeout, 1);
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("tmo_cleared", bus.o_timeout, 0);
    rst = 1'b0;
    @(negedge clk);
`else
    $display("[TB] unbounded WAIT without timeout feature");
    ctrl_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 24'h000077, 16'h0, 1'b0, 24'h0);
    waitStb(10, lat);
    checkOutput("nto_stb_lat", lat, 2);
    waitDone(1'b1, 300, lat, other_seen, stb_seen);
    checkOutput("nto_no_done", lat, -1);
    checkOutput("nto_owner_held", bus.o_owner, 2'b01);
    checkOutput("nto_flag", bus.o_timeout, 0);
    applyStimulus(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 24'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ctrl_en = 1'b1;
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
